// File: rtl/sim_monitor_pkg.sv
// Shared types and constants for the simulation commit monitor.
// The lane struct carries pc/wdata at MON_XLEN bits, which is the default
// XLEN of the monitor; the top casts its port slices into it.
package sim_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    localparam logic [31:0] TRAP_INST_DEF = 32'h0010_0073;
    localparam logic [4:0]  A0_IDX        = 5'd10;
    localparam int unsigned MON_XLEN      = 32;

    typedef struct packed {
        logic                valid;
        logic [31:0]         inst;
        logic [MON_XLEN-1:0] pc;
        logic                wen;
        logic [4:0]          rd;
        logic [MON_XLEN-1:0] wdata;
    } commit_lane_t;

    // True when the lane writes the architectural a0 register.
    function automatic logic is_a0_write(input commit_lane_t lane);
        return lane.wen && (lane.rd == A0_IDX);
    endfunction

endpackage

// File: rtl/sim_commit_lane_scan.sv
// Combinational scan of one commit bundle: retires lanes in order up to and
// including the first trap, counts them, and forwards the newest a0 value.
module sim_commit_lane_scan
    import sim_monitor_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter logic [31:0] TRAP_INST    = TRAP_INST_DEF,
    parameter int unsigned CNT_W        = $clog2(COMMIT_WIDTH + 1),
    parameter int unsigned IDX_W        = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
    input  commit_lane_t [COMMIT_WIDTH-1:0] lanes_i,
    input  logic [MON_XLEN-1:0]             a0_i,
    output logic [COMMIT_WIDTH-1:0]         retire_mask_o,
    output logic [CNT_W-1:0]                retire_cnt_o,
    output logic                            trap_hit_o,
    output logic [IDX_W-1:0]                trap_idx_o,
    output logic [MON_XLEN-1:0]             a0_fwd_o
);

    // The PC field is consumed by the top only for the trapping lane.
    logic pc_unused_s;

    // Walk lanes oldest-first; once a trap is seen younger lanes are dropped.
    always_comb begin
        retire_mask_o = '0;
        retire_cnt_o  = '0;
        trap_hit_o    = 1'b0;
        trap_idx_o    = '0;
        a0_fwd_o      = a0_i;
        for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
            if (lanes_i[i].valid && !trap_hit_o) begin
                retire_mask_o[i] = 1'b1;
                retire_cnt_o     = retire_cnt_o + CNT_W'(1);
                if (is_a0_write(lanes_i[i])) begin
                    a0_fwd_o = lanes_i[i].wdata;
                end else begin
                    a0_fwd_o = a0_fwd_o;
                end
                if (lanes_i[i].inst == TRAP_INST) begin
                    trap_hit_o = 1'b1;
                    trap_idx_o = IDX_W'(i);
                end else begin
                    trap_idx_o = trap_idx_o;
                end
            end else begin
                retire_mask_o[i] = 1'b0;
            end
        end
    end

    // Fold the PC bits so the whole lane bundle is consumed here.
    always_comb begin
        pc_unused_s = 1'b0;
        for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
            pc_unused_s = pc_unused_s ^ (^lanes_i[i].pc);
        end
    end

endmodule

// File: rtl/sim_commit_monitor.sv
// Simulation commit monitor: counts cycles and retired instructions, shadows
// a0, ends the run on ebreak or a no-commit watchdog, and raises finish/pass
// after a drain window. Define SIM_COMMIT_TRACE_EN for a per-lane retire trace
// and end-of-run summaries; port behaviour is the same either way.
module sim_commit_monitor
    import sim_monitor_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned WDT_CYCLES   = 4096,
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter logic [31:0] TRAP_INST    = TRAP_INST_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [COMMIT_WIDTH-1:0]    cmt_valid,
    input  logic [COMMIT_WIDTH*32-1:0] cmt_inst,
    input  logic [COMMIT_WIDTH*XLEN-1:0] cmt_pc,
    input  logic [COMMIT_WIDTH-1:0]    cmt_wen,
    input  logic [COMMIT_WIDTH*5-1:0]  cmt_rd,
    input  logic [COMMIT_WIDTH*XLEN-1:0] cmt_wdata,
    output logic [63:0]                cycle_cnt,
    output logic [63:0]                instr_cnt,
    output logic [XLEN-1:0]            trap_pc,
    output logic                       timeout,
    output logic                       finish,
    output logic                       pass
);

    localparam int unsigned CNT_W = $clog2(COMMIT_WIDTH + 1);
    localparam int unsigned IDX_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
    localparam int unsigned DR_W  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST   = WDT_W'(WDT_CYCLES - 1);
    localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(DRAIN_CYCLES - 1);

    mon_state_e state_q, state_d;
    logic [63:0]      cycle_q, cycle_d;
    logic [63:0]      instr_q, instr_d;
    logic [XLEN-1:0]  a0_q, a0_d;
    logic [XLEN-1:0]  trap_pc_q, trap_pc_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic [DR_W-1:0]  drain_q, drain_d;
    logic             trap_ok_q, trap_ok_d;
    logic             timeout_q, timeout_d;
    logic             finish_q, finish_d;
    logic             pass_q, pass_d;

    commit_lane_t [COMMIT_WIDTH-1:0] lanes_s;
    logic [COMMIT_WIDTH-1:0] retire_mask_s;
    logic [CNT_W-1:0]        retire_cnt_s;
    logic                    trap_hit_s;
    logic [IDX_W-1:0]        trap_idx_s;
    logic [MON_XLEN-1:0]     a0_fwd_s;
    logic                    commit_s;
    logic                    run_cycle_s;
    logic                    trap_s;
    logic                    wdt_expire_s;
    logic                    drain_last_s;

    // Unpack the flat retire port into per-lane records.
    always_comb begin
        lanes_s = '0;
        for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
            lanes_s[i].valid = cmt_valid[i];
            lanes_s[i].inst  = cmt_inst[i*32 +: 32];
            lanes_s[i].pc    = MON_XLEN'(cmt_pc[i*XLEN +: XLEN]);
            lanes_s[i].wen   = cmt_wen[i];
            lanes_s[i].rd    = cmt_rd[i*5 +: 5];
            lanes_s[i].wdata = MON_XLEN'(cmt_wdata[i*XLEN +: XLEN]);
        end
    end

    sim_commit_lane_scan #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .TRAP_INST    (TRAP_INST),
        .CNT_W        (CNT_W),
        .IDX_W        (IDX_W)
    ) u_scan (
        .lanes_i       (lanes_s),
        .a0_i          (MON_XLEN'(a0_q)),
        .retire_mask_o (retire_mask_s),
        .retire_cnt_o  (retire_cnt_s),
        .trap_hit_o    (trap_hit_s),
        .trap_idx_o    (trap_idx_s),
        .a0_fwd_o      (a0_fwd_s)
    );

    // The oldest valid lane always retires, so any retire means a commit cycle.
    assign commit_s     = |retire_mask_s;
    assign run_cycle_s  = (state_q == RUN) || ((state_q == IDLE) && commit_s);
    assign trap_s       = run_cycle_s && trap_hit_s;
    assign wdt_expire_s = (state_q == RUN) && !commit_s && (wdt_q == WDT_LAST);
    assign drain_last_s = (drain_q == DRAIN_LAST);

    // State register for the run-control FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: the first commit starts the run, trap or watchdog ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (commit_s) begin
                    if (trap_hit_s) state_d = DRAIN;
                    else            state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (trap_s)            state_d = DRAIN;
                else if (wdt_expire_s) state_d = DRAIN;
                else                   state_d = RUN;
            end
            DRAIN: begin
                if (drain_last_s) state_d = DONE;
                else              state_d = DRAIN;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Counter, shadow and result updates for the current state.
    always_comb begin
        cycle_d   = cycle_q;
        instr_d   = instr_q;
        a0_d      = a0_q;
        trap_pc_d = trap_pc_q;
        wdt_d     = wdt_q;
        drain_d   = drain_q;
        trap_ok_d = trap_ok_q;
        timeout_d = timeout_q;
        finish_d  = finish_q;
        pass_d    = pass_q;
        if (run_cycle_s) begin
            cycle_d = cycle_q + 64'd1;
            instr_d = instr_q + 64'(retire_cnt_s);
            a0_d    = XLEN'(a0_fwd_s);
            drain_d = '0;
            if (commit_s) wdt_d = '0;
            else          wdt_d = wdt_q + WDT_W'(1);
            if (trap_s) begin
                trap_pc_d = XLEN'(lanes_s[trap_idx_s].pc);
                trap_ok_d = (a0_fwd_s == '0);
            end else if (wdt_expire_s) begin
                timeout_d = 1'b1;
                trap_pc_d = '0;
                trap_ok_d = 1'b0;
            end else begin
                trap_pc_d = trap_pc_q;
            end
        end else if (state_q == DRAIN) begin
            cycle_d = cycle_q + 64'd1;
            if (drain_last_s) begin
                finish_d = 1'b1;
                pass_d   = trap_ok_q;
            end else begin
                drain_d = drain_q + DR_W'(1);
            end
        end else begin
            cycle_d = cycle_q;
        end
    end

    // Datapath registers; everything clears on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q   <= 64'd0;
            instr_q   <= 64'd0;
            a0_q      <= '0;
            trap_pc_q <= '0;
            wdt_q     <= '0;
            drain_q   <= '0;
            trap_ok_q <= 1'b0;
            timeout_q <= 1'b0;
            finish_q  <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            a0_q      <= a0_d;
            trap_pc_q <= trap_pc_d;
            wdt_q     <= wdt_d;
            drain_q   <= drain_d;
            trap_ok_q <= trap_ok_d;
            timeout_q <= timeout_d;
            finish_q  <= finish_d;
            pass_q    <= pass_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
    assign trap_pc   = trap_pc_q;
    assign timeout   = timeout_q;
    assign finish    = finish_q;
    assign pass      = pass_q;

`ifdef SIM_COMMIT_TRACE_EN
    // Retire trace per processed lane, plus a summary line on trap or timeout.
    always @(posedge clock) begin
        if (reset && run_cycle_s) begin
            for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
                if (retire_mask_s[i]) begin
                    if (lanes_s[i].wen && (lanes_s[i].rd != 5'd0))
                        $display("%0d %h %h x%0d=%h", cycle_q, lanes_s[i].pc,
                                 lanes_s[i].inst, lanes_s[i].rd, lanes_s[i].wdata);
                    else
                        $display("%0d %h %h", cycle_q, lanes_s[i].pc, lanes_s[i].inst);
                end
            end
            if (trap_s)
                $display("trap pc=%h instr=%0d cycles=%0d ipc=%f",
                         lanes_s[trap_idx_s].pc, instr_d, cycle_d,
                         real'(instr_d) / real'(cycle_d));
            else if (wdt_expire_s)
                $display("timeout instr=%0d cycles=%0d ipc=%f", instr_d, cycle_d,
                         real'(instr_d) / real'(cycle_d));
        end
    end
`endif

endmodule

// File: doc/sim_commit_monitor.md
Name: sim_commit_monitor

Overview:
- Simulation-only block sitting between SimTop's retire port and the testbench top.
- Consumes the core's per-cycle commit bundle and keeps cycle and instruction counters.
- Shadows architectural x10 (a0) and detects the ebreak end-of-test trap and a no-commit watchdog.
- Drives finish/pass so the bench can end the run after a drain window.

Parameters:
- COMMIT_WIDTH, 2, commit lanes per cycle; lane 0 is oldest.
- XLEN, 32, data width of the register write-back.
- WDT_CYCLES, 4096, consecutive commit-free cycles in RUN before a timeout.
- DRAIN_CYCLES, 16, cycles between trap/timeout and finish.
- TRAP_INST, 32'h00100073, encoding treated as the end-of-test trap (ebreak).

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cmt_valid  in  COMMIT_WIDTH  per-lane commit valid.
- cmt_inst  in  COMMIT_WIDTH*32  per-lane instruction word.
- cmt_pc  in  COMMIT_WIDTH*XLEN  per-lane PC.
- cmt_wen  in  COMMIT_WIDTH  per-lane rd write enable.
- cmt_rd  in  COMMIT_WIDTH*5  per-lane rd index.
- cmt_wdata  in  COMMIT_WIDTH*XLEN  per-lane rd write data.
- cycle_cnt  out  64  cycles spent in RUN and DRAIN.
- instr_cnt  out  64  instructions retired, trap included.
- trap_pc  out  XLEN  PC of the trapping instruction; 0 on timeout.
- timeout  out  1  sticky; watchdog expired.
- finish  out  1  sticky; run complete.
- pass  out  1  valid when finish=1; high only for a trap with a0==0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all counters, the a0 shadow, trap_pc, timeout, finish and pass go to 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on the first cycle in which any cmt_valid bit is set. That cycle's commits are processed as a RUN cycle. cycle_cnt does not count in IDLE, so reset latency is excluded.
- RUN, cycle counting: cycle_cnt increments every cycle, including the entry cycle.
- RUN, lane processing in ascending order:
  - A valid lane increments instr_cnt.
  - If cmt_wen=1 and cmt_rd==10, the lane updates the a0 shadow. Writes to rd 0 are ignored.
- First valid lane k with cmt_inst==TRAP_INST:
  - Lanes above k are discarded: not counted, no shadow update.
  - trap_pc=cmt_pc[k]; state -> DRAIN.
  - pass is evaluated on the a0 value including writes from lanes below k in the same cycle (forwarded, not the registered shadow).
- Simultaneous events: multiple lanes writing x10 in one cycle -> the highest-numbered valid lane at or below the trap wins.
- Watchdog:
  - Counter resets to 0 on any commit cycle and increments otherwise.
  - When it reaches WDT_CYCLES-1 in a commit-free cycle: timeout=1, pass=0, trap_pc=0, state -> DRAIN.
  - A trap cycle is a commit cycle, so trap and timeout can never coincide.
- DRAIN:
  - Commits ignored; cycle_cnt still increments.
  - A drain counter runs from 0; after DRAIN_CYCLES cycles -> DONE, asserting finish on the DONE entry edge.
  - DRAIN_CYCLES=0 is illegal; the minimum is 1.
- DONE: all outputs frozen; only reset leaves this state.
- Counter wrap: 64-bit counters wrap modulo 2^64; no saturation.
- Reset mid-operation: returns to IDLE immediately and clears everything. The next run behaves as from power-on.
- All outputs are registered; none are combinational from inputs.

Optional Feature:
- Macro: SIM_COMMIT_TRACE_EN.
- When defined: each processed lane in RUN $displays "cycle pc inst [rd=wdata]". Trap and timeout each print a one-line summary with counters and IPC (instr_cnt/cycle_cnt, real).
- When undefined: no $display or real arithmetic is compiled, and port behaviour is identical.

Decomposition:
- Package sim_monitor_pkg:
  - FSM state enum (IDLE/RUN/DRAIN/DONE).
  - TRAP_INST default, A0_IDX=5'd10.
  - Commit lane struct {valid, inst, pc, wen, rd, wdata}.
- One natural sub-module, sim_commit_lane_scan. It is combinational over the lanes and produces:
  - the retire mask (lanes up to and including the first trap);
  - the retire count;
  - the trap hit and its lane index;
  - the forwarded a0 value.
- The top holds the FSM, counters and watchdog.

Test Plan:
- Hold reset=0 for 5 cycles, then release with no commits for 10 cycles -> state IDLE, cycle_cnt=0, finish=0.
- Commit 2 lanes per cycle for 100 cycles (no trap) -> instr_cnt=200, cycle_cnt=100, timeout=0.
- Lane0 writes x10=0 and lane1 is ebreak at pc 0x80000100, in the same cycle -> trap_pc=0x80000100, instr_cnt incremented by 2, finish rises exactly DRAIN_CYCLES cycles later, pass=1.
- Lane0 ebreak with a0 shadow=1 and lane1 valid in the same cycle -> lane1 not counted, finish with pass=0.
- Run, then stop commits for WDT_CYCLES cycles -> timeout=1, trap_pc=0, finish after the drain, pass=0.
- Pulse reset=0 for 1 cycle in mid-DRAIN -> all outputs 0 next cycle; a subsequent run passes normally.
